// File: rtl/fifo_wr_burst_driver.sv
// rtl/fifo_wr_burst_driver.sv - wclk-domain burst write driver for the async FIFO write port
`timescale 1ns/1ps

module fifo_wr_burst_driver #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int BURST   = 4,
  parameter int AFULL   = 12,
  parameter int TIMEOUT = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic [AW:0]      wrptr,
  input  logic [AW:0]      q2_rptr,
  input  logic             wr_full,
  output logic             wren,
  output logic [WIDTH-1:0] wdata,
  output logic [AW:0]      wr_level,
  output logic             wr_afull,
  output logic             burst_active
);

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_L   = (AW+1)'(BURST);
  localparam logic [AW:0] AFULL_L   = (AW+1)'(AFULL);
  localparam logic [AW:0] ONE_L     = (AW+1)'(1);
  localparam logic [7:0]  TIMEOUT_L = 8'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             hold_valid, hold_last;
  logic [WIDTH-1:0] hold_data;
  logic [AW:0]      wbin, rbin, space;
  logic             load;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // rptr arrives through a synchronizer, so space is a safe underestimate
  assign wbin     = gray2bin(wrptr);
  assign rbin     = gray2bin(q2_rptr);
  assign wr_level = wbin - rbin;
  assign space    = DEPTH_L - wr_level;
  assign wr_afull = (wr_level >= AFULL_L);

  assign wren         = (state_q == ST_BURST) && hold_valid && !wr_full;
  assign wdata        = hold_data;
  assign s_ready      = !hold_valid || wren;
  assign load         = s_valid && s_ready;
  assign burst_active = (state_q == ST_BURST);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_last  <= s_last;
      hold_data  <= s_data;
    end else if (wren) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_valid && space >= BURST_L) begin
          state_d = ST_BURST;
          count_d = BURST_L;
          tcnt_d  = '0;
        end else if (hold_valid && (hold_last || tcnt_q == TIMEOUT_L) && space >= ONE_L) begin
          // partial burst sized to what is guaranteed to fit
          state_d = ST_BURST;
          count_d = (space < BURST_L) ? space : BURST_L;
          tcnt_d  = '0;
        end else if (hold_valid && tcnt_q != TIMEOUT_L) begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_BURST: begin
        if (wren) begin
          count_d = count_q - ONE_L;
          if (count_q == ONE_L || hold_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_burst_driver.sv
// tb/tb_fifo_wr_burst_driver.sv - directed scoreboard bench for fifo_wr_burst_driver
`timescale 1ns/1ps

module tb_fifo_wr_burst_driver;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [4:0] wrptr = '0;
  logic [4:0] q2_rptr = '0;
  logic       wr_full = 1'b0;
  logic       wren;
  logic [7:0] wdata;
  logic [4:0] wr_level;
  logic       wr_afull;
  logic       burst_active;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_edge = -1;
  logic [7:0] sb[$];

  fifo_wr_burst_driver dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .wrptr(wrptr), .q2_rptr(q2_rptr), .wr_full(wr_full),
    .wren(wren), .wdata(wdata), .wr_level(wr_level), .wr_afull(wr_afull),
    .burst_active(burst_active)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  // writes happen at the edge following this negedge
  always @(negedge wclk) begin
    if (wr_full === 1'b1) chk("wren_while_full", {31'd0, wren}, 32'd0);
    if (wren === 1'b1) begin
      wr_cnt++;
      last_wr_edge = cyc + 1;
      if (sb.size() == 0) chk("unexpected_write", {24'd0, wdata}, 32'hFFFF);
      else chk("wdata", {24'd0, wdata}, {24'd0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int edge_n);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!acc && n < 50) begin
      @(negedge wclk);
      acc = s_ready;
      @(posedge wclk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    if (acc) sb.push_back(d);
    else chk("send_timeout", 32'd0, 32'd1);
    edge_n = cyc;
  endtask

  initial begin
    int n0, nx, w0, t0;

    // reset with upstream offering a word
    s_valid = 1'b1;
    s_data = 8'h11;
    step();
    step();
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_burst_active", {31'd0, burst_active}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    wrst = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_level", {27'd0, wr_level}, 32'd0);
    chk("rst_afull", {31'd0, wr_afull}, 32'd0);

    // full 4-word burst
    w0 = wr_cnt;
    send(8'hA0, 1'b0, n0);
    send(8'hA1, 1'b0, nx);
    send(8'hA2, 1'b0, nx);
    send(8'hA3, 1'b0, nx);
    step();
    chk("full_last_edge", 32'(last_wr_edge), 32'(n0 + 5));
    chk("full_count", 32'(wr_cnt - w0), 32'd4);
    chk("full_idle", {31'd0, burst_active}, 32'd0);

    // space gating at level 12
    wrptr = gray(12);
    q2_rptr = gray(0);
    #1;
    chk("gate_level12", {27'd0, wr_level}, 32'd12);
    chk("gate_afull12", {31'd0, wr_afull}, 32'd1);
    send(8'hB0, 1'b0, n0);
    step();
    step();
    chk("gate_b0_edge", 32'(last_wr_edge), 32'(n0 + 2));
    chk("gate_b0_active", {31'd0, burst_active}, 32'd1);
    send(8'hB1, 1'b1, nx);
    step();
    chk("gate_b1_idle", {31'd0, burst_active}, 32'd0);

    // level 13: no start until read pointer advances
    wrptr = gray(13);
    w0 = wr_cnt;
    send(8'hC0, 1'b0, n0);
    repeat (4) step();
    chk("gate13_nowrite", 32'(wr_cnt - w0), 32'd0);
    chk("gate13_idle", {31'd0, burst_active}, 32'd0);
    q2_rptr = gray(1);
    t0 = cyc;
    step();
    step();
    chk("gate13_release_edge", 32'(last_wr_edge), 32'(t0 + 2));
    send(8'hC1, 1'b1, nx);
    step();
    chk("gate13_end_idle", {31'd0, burst_active}, 32'd0);

    // pointer wrap and completely full
    wrptr = gray(3);
    q2_rptr = gray(30);
    #1;
    chk("wrap_level5", {27'd0, wr_level}, 32'd5);
    chk("wrap_afull5", {31'd0, wr_afull}, 32'd0);
    wrptr = gray(16);
    q2_rptr = gray(0);
    #1;
    chk("full_level16", {27'd0, wr_level}, 32'd16);
    chk("full_afull16", {31'd0, wr_afull}, 32'd1);
    w0 = wr_cnt;
    send(8'hD0, 1'b1, n0);
    repeat (12) step();
    chk("full16_nowrite", 32'(wr_cnt - w0), 32'd0);
    chk("full16_s_ready", {31'd0, s_ready}, 32'd0);
    wrptr = gray(8);
    t0 = cyc;
    step();
    step();
    chk("full16_release_edge", 32'(last_wr_edge), 32'(t0 + 2));
    chk("full16_idle", {31'd0, burst_active}, 32'd0);

    // flush by last
    wrptr = gray(0);
    send(8'h55, 1'b1, n0);
    step();
    step();
    chk("flush_last_edge", 32'(last_wr_edge), 32'(n0 + 2));
    chk("flush_last_idle", {31'd0, burst_active}, 32'd0);

    // flush by timeout with space 3
    wrptr = gray(13);
    w0 = wr_cnt;
    send(8'h66, 1'b0, n0);
    repeat (9) step();
    chk("timeout_not_yet", 32'(wr_cnt - w0), 32'd0);
    step();
    chk("timeout_edge", 32'(last_wr_edge), 32'(n0 + 10));
    chk("timeout_count", 32'(wr_cnt - w0), 32'd1);
    send(8'h67, 1'b1, nx);
    step();
    chk("timeout_end_idle", {31'd0, burst_active}, 32'd0);

    // stall on wr_full mid-burst
    wrptr = gray(0);
    send(8'hE0, 1'b0, n0);
    send(8'hE1, 1'b0, nx);
    chk("stall_pre_wren", {31'd0, wren}, 32'd1);
    wr_full = 1'b1;
    #1;
    chk("stall_wren_drop", {31'd0, wren}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wren", {31'd0, wren}, 32'd0);
      chk("stall_wdata", {24'd0, wdata}, 32'hE1);
      chk("stall_active", {31'd0, burst_active}, 32'd1);
    end
    wr_full = 1'b0;
    send(8'hE2, 1'b0, nx);
    send(8'hE3, 1'b0, nx);
    chk("stall_still_active", {31'd0, burst_active}, 32'd1);
    step();
    chk("stall_end_idle", {31'd0, burst_active}, 32'd0);

    // reset mid-burst drops the held word
    send(8'hF0, 1'b0, n0);
    step();
    chk("rstmid_pre_wren", {31'd0, wren}, 32'd1);
    wrst = 1'b1;
    #1;
    chk("rstmid_wren", {31'd0, wren}, 32'd0);
    chk("rstmid_idle", {31'd0, burst_active}, 32'd0);
    chk("rstmid_s_ready", {31'd0, s_ready}, 32'd1);
    if (sb.size() != 0) void'(sb.pop_back());
    step();
    wrst = 1'b0;
    w0 = wr_cnt;
    repeat (4) step();
    chk("rstmid_nowrite", 32'(wr_cnt - w0), 32'd0);
    send(8'h77, 1'b1, n0);
    step();
    step();
    chk("recover_edge", 32'(last_wr_edge), 32'(n0 + 2));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
